// File: rtl/div_pkg.sv
// div_pkg -- constants and the state type shared by the restoring-division
// controller, the datapath top level and the bench.
//   DIV_N       : number of shift/compare iterations (datapath word width)
//   DIV_CW      : iteration counter width (2**DIV_CW > DIV_N)
//   div_state_t : controller state encoding
package div_pkg;

  localparam int DIV_N  = 10;
  localparam int DIV_CW = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SHIFT = 3'd3,
    ST_SUB   = 3'd4,
    ST_FINAL = 3'd5,
    ST_LATCH = 3'd6,
    ST_DONE  = 3'd7
  } div_state_t;

endpackage

// File: rtl/div_controller.sv
// div_controller -- sequencing FSM for the 10-bit restoring divider.
//
// Steps the A/Q/B/E datapath through load, a zero-divisor check, N
// shift/subtract iterations and a final quotient shift, then pulses done
// with divide-by-zero and overflow status.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start             : request a division (only honoured in IDLE and DONE)
//   ge, Bz, Qnz       : datapath status (A >= B, divisor zero, Q[9:4] != 0)
//   clrA, ldA, shA    : A register clear / load difference / shift left
//   ldQ, shQ          : Q register load dividend / shift left with E in LSB
//   ldB               : B register load divisor
//   ldE               : E flip-flop load ge
//   busy              : high in every state except IDLE
//   done              : one-cycle completion pulse
//   dvz, ovf          : status flags, held until the next accepted start
module div_controller
  import div_pkg::*;
#(
  parameter int N  = DIV_N,
  parameter int CW = DIV_CW
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ge,
  input  logic Bz,
  input  logic Qnz,
  output logic clrA,
  output logic ldA,
  output logic shA,
  output logic ldQ,
  output logic shQ,
  output logic ldB,
  output logic ldE,
  output logic busy,
  output logic done,
  output logic dvz,
  output logic ovf
);

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dvz_q, dvz_d;
  logic          ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvz_q   <= dvz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvz_d   = dvz_q;
    ovf_d   = ovf_q;
    clrA    = 1'b0;
    ldA     = 1'b0;
    shA     = 1'b0;
    ldQ     = 1'b0;
    shQ     = 1'b0;
    ldB     = 1'b0;
    ldE     = 1'b0;
    done    = 1'b0;
    busy    = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          dvz_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        clrA    = 1'b1;
        ldQ     = 1'b1;
        ldB     = 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (Bz) begin
          dvz_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shA     = 1'b1;
        shQ     = 1'b1;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        // Restoring step: the difference is only written back when it is
        // non-negative; E records the quotient bit for the next Q shift.
        ldE = 1'b1;
        ldA = ge;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FINAL;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_FINAL: begin
        // Q alone shifts once more to take the last quotient bit; the stale
        // E bit inserted by the first SHIFT falls off the top.
        shQ     = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        ovf_d   = Qnz;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          dvz_d   = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dvz = dvz_q;
  assign ovf = ovf_q;

endmodule

// File: doc/div_controller.md
# div_controller

Sequencing FSM for the 10-bit restoring-division datapath. Accepts a start request. Drives the A/Q/B/E register controls through load, a zero-divisor check, N shift/compare iterations and a final quotient shift. Reports completion with divide-by-zero and quotient-overflow status. Sits beside the datapath in the divider top level; the datapath's ge, Qnz and Bz feed back into this block.

## Interface
Parameters:
- N, 10, number of shift/compare iterations (equals datapath word width)
- CW, 4, iteration counter width; must satisfy 2^CW > N

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a division; sampled only in IDLE and DONE
- ge  input  1  datapath: A >= {0,B}, combinational from current A/B
- Bz  input  1  datapath: divisor register is zero
- Qnz  input  1  datapath: quotient[9:4] nonzero
- clrA, ldA, shA  output  1 each  A register clear / load diff / shift left
- ldQ, shQ  output  1 each  Q register load dividend / shift left (LSB <- E)
- ldB  output  1  B register load divisor
- ldE  output  1  E flip-flop load ge
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- dvz  output  1  divide-by-zero status, valid with done, held until next accepted start
- ovf  output  1  quotient >= 16 status, valid with done, held until next accepted start

## Operation
- States: IDLE, LOAD, CHECK, SHIFT, SUB, FINAL, LATCH, DONE.
- IDLE: all controls 0. If start=1, go to LOAD and clear dvz, ovf and the iteration counter.
- LOAD: clrA=1, ldQ=1, ldB=1. Go to CHECK.
- CHECK: no controls. If Bz=1, set dvz and go to DONE. Otherwise go to SHIFT.
- SHIFT: shA=1, shQ=1 ({A,Q} shift left as one unit; Q LSB <- E). Go to SUB.
- SUB: ldE=1, ldA=ge (A <- A-B only when ge=1). Increment counter. If the counter has reached N-1 before the increment, go to FINAL; otherwise go to SHIFT.
- FINAL: shQ=1 only, inserting the last quotient bit. The stale first E bit shifts out.
- LATCH: no controls; ovf <= Qnz. Go to DONE.
- DONE: done=1. If start=1, go to LOAD and clear the flags (back-to-back). Otherwise go to IDLE.
- Result: Q = quotient, A[9:0] = remainder, both valid from the DONE cycle onward until the next LOAD.
- At most one datapath control group is active per cycle. ldA and shA are never asserted together.
- Control outputs are Moore-decoded from state. The only exception is ldA in SUB, which is gated by ge.

## Timing
- Reset (async, any state, mid-operation included): state=IDLE, counter=0. All outputs 0, including dvz and ovf. Datapath contents are don't-care.
- Normal latency: start sampled high in IDLE at edge 0. LOAD is cycle 1, CHECK 2, SHIFT/SUB cycles 3–22, FINAL 23, LATCH 24, DONE (done=1) 25.
- Zero divisor: LOAD cycle 1, CHECK cycle 2, DONE cycle 3 with dvz=1 and ovf=0. No SHIFT/SUB/ldE activity occurs.
- start while busy (LOAD..LATCH) is ignored and not queued.
- start held high continuously: DONE is followed directly by LOAD. The period is 25 cycles from one LOAD to the next.
- Counter never exceeds N-1. Wrap-around is unreachable; any illegal state encoding returns to IDLE.

## Structure
- Shared package div_pkg holds the state enum (div_state_t), DIV_N=10, and DIV_CW=4. The datapath top and the bench import the same constants.
- Single module; the iteration counter is inline. No sub-module is needed.
- Top level div_top instantiates div_controller and the datapath, wiring the control/status nets by name.

## Test plan
- 100 / 7: start one cycle → done in cycle 25, quotient=14, remainder=2, dvz=0, ovf=0; exactly 10 shA pulses, 11 shQ pulses.
- 1000 / 3: → quotient=333, remainder=1, ovf=1, dvz=0.
- 517 / 0: → done in cycle 3, dvz=1, ovf=0; no shA/ldE pulses; flags held high in IDLE until next start.
- 5 / 9 and 1023 / 1: → (0 r 5, ovf=0) and (1023 r 0, ovf=1); ldA asserted only in SUB cycles with ge=1.
- Pulse start again at cycle 10 of an operation → ignored, single done at 25. Then start held high → back-to-back ops, done every 25 cycles, flags cleared at each LOAD.
- Assert rst at cycle 12 mid-iteration → all outputs 0 immediately (async); a fresh 100 / 7 afterward completes correctly.
